// File: rtl/ras.sv
// Return address stack: circular store of truncated link targets with a top/count checkpoint and restore.
// Zero-latency combinational read of the top entry; no backpressure, overflow overwrites oldest, underflow ignored.
module ras #(
  parameter int RAS_DEPTH        = 8,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int RAS_TARGET_WIDTH = 12
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pred_target,
  output logic                        pred_empty,
  output logic [LOG_RAS_DEPTH-1:0]    pred_index,
  output logic [LOG_RAS_DEPTH:0]      pred_count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
  input  logic [LOG_RAS_DEPTH:0]      restore_count
);

  localparam logic [LOG_RAS_DEPTH:0]   CNT_FULL = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
  localparam logic [LOG_RAS_DEPTH:0]   CNT_ONE  = (LOG_RAS_DEPTH+1)'(1);
  localparam logic [LOG_RAS_DEPTH-1:0] IDX_ONE  = LOG_RAS_DEPTH'(1);

  logic [RAS_TARGET_WIDTH-1:0] entry [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    top, top_nxt, wr_idx;
  logic [LOG_RAS_DEPTH:0]      count, count_nxt;
  logic                        wr_en;

  assign pred_target = entry[top];
  assign pred_empty  = (count == '0);
  assign pred_index  = top;
  assign pred_count  = count;

  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = top;
    if (restore_valid) begin
      top_nxt   = restore_index;
      count_nxt = (restore_count > CNT_FULL) ? CNT_FULL : restore_count;
    end else if (push_valid && pop_valid) begin
      wr_en     = 1'b1;
      count_nxt = (count == '0) ? CNT_ONE : count;
    end else if (push_valid) begin
      top_nxt   = top + IDX_ONE;
      wr_en     = 1'b1;
      wr_idx    = top + IDX_ONE;
      count_nxt = (count == CNT_FULL) ? count : count + CNT_ONE;
    end else if (pop_valid && count != '0) begin
      top_nxt   = top - IDX_ONE;
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      top   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
    end else begin
      top   <= top_nxt;
      count <= count_nxt;
      if (wr_en) entry[wr_idx] <= push_target;
    end
  end

endmodule

// File: doc/ras.md
Name: ras

Overview:
- Return address stack for the fetch-stage branch predictor.
- Sits beside the BTB lookup: a BTB hit marked as a call pushes the link target, and a hit marked as a return pops the predicted target.
- Targets are stored as truncated low PC bits; the upper bits come from the upper-PC table.
- Provides a checkpoint (top index plus count) with every prediction, so the backend can restore the stack on a mispredict or flush.

Parameters:
- RAS_DEPTH, 8, number of stack entries; must be a power of 2, at least 2.
- LOG_RAS_DEPTH, $clog2(RAS_DEPTH), width of the top pointer.
- RAS_TARGET_WIDTH, 12, stored target width (matches BTB_TARGET_WIDTH).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- push_valid  in  1  call predicted this cycle.
- push_target  in  RAS_TARGET_WIDTH  link target to push.
- pop_valid  in  1  return predicted this cycle.
- pred_target  out  RAS_TARGET_WIDTH  entry at the current top (combinational read).
- pred_empty  out  1  count == 0.
- pred_index  out  LOG_RAS_DEPTH  current top pointer (checkpoint).
- pred_count  out  LOG_RAS_DEPTH+1  current valid-entry count (checkpoint).
- restore_valid  in  1  restore checkpoint from backend.
- restore_index  in  LOG_RAS_DEPTH  top pointer to restore.
- restore_count  in  LOG_RAS_DEPTH+1  count to restore; values above RAS_DEPTH are saturated to RAS_DEPTH.

Behaviour:
- Storage:
  - Circular array of RAS_DEPTH entries, top pointer `top`, and `count` in 0..RAS_DEPTH.
  - Only CLK and nRST are sequential; all state updates on the rising edge of CLK.
- Reset (nRST low, async):
  - All entries = 0, top = 0, count = 0.
  - Therefore pred_target = 0, pred_empty = 1, pred_index = 0, pred_count = 0.
  - Reset asserted mid-operation discards all state immediately.
- Read path:
  - pred_target = entry[top] and is combinational from state; there is no read latency.
  - Outputs reflect state before this cycle's push, pop or restore.
  - pred_target is driven even when empty (stale or zero data); the consumer must qualify it with pred_empty.
- Priority: restore > push/pop.
- restore_valid = 1:
  - top <= restore_index; count <= min(restore_count, RAS_DEPTH).
  - Entries are not modified.
  - push_valid and pop_valid in the same cycle are ignored.
- push only:
  - top <= top+1 mod RAS_DEPTH; entry[top+1] <= push_target.
  - count <= min(count+1, RAS_DEPTH).
  - When count == RAS_DEPTH, the oldest entry is overwritten silently (overflow is not an error).
- pop only:
  - If count > 0: top <= top-1 mod RAS_DEPTH; count <= count-1.
  - If count == 0: no state change (underflow ignored).
- push and pop together (return-and-call):
  - entry[top] <= push_target; top unchanged.
  - count <= count if count > 0, else 1.
- Neither push nor pop: hold all state.
- Wrap-around: pointer arithmetic is modulo RAS_DEPTH in both directions (7+1 -> 0, 0-1 -> 7).
- Restore does not rewrite entries, so data corrupted by wrong-path pushes remains corrupted. This is accepted as a prediction-only inaccuracy, not a functional error.

Test Plan:
- Reset, then push 0x111, 0x222, 0x333 on consecutive cycles -> pred_index = 3, pred_count = 3, pred_target = 0x333; then pop twice -> pred_target = 0x111, pred_index = 1, pred_count = 1.
- Reset, pop with count = 0 -> pred_index = 0, pred_count = 0, pred_empty = 1, pred_target = 0 held.
- 10 consecutive pushes of 0x001..0x00A -> pred_count saturates at 8, pred_index = 2 (wrapped), pred_target = 0x00A; 8 pops return 0x00A down to 0x003, then pred_empty = 1.
- With top = 2, count = 2 (entries 0xAAA, 0xBBB), assert push 0xCCC and pop together -> pred_index = 2, pred_count = 2, pred_target = 0xCCC, entry 1 still 0xAAA after a pop.
- Checkpoint index = 1, count = 1 (entry 1 = 0x555); push wrong-path 0x777 and 0x888; assert restore_valid with (1, 1) plus simultaneous push 0x999 -> pred_index = 1, pred_count = 1, pred_target = 0x555, push ignored.
- Assert nRST low asynchronously mid-sequence with count = 5 -> all outputs go to their reset values before the next CLK edge.
